// File: rtl/temp_disp_ctrl.sv
// Strobed signed-byte to 3-digit 7-segment display: 7-cycle double-dabble, commit 8 cycles after the strobe.
// Strobes arriving while busy are dropped; the digit scan free-runs, changing an/seg every REFRESH_DIV cycles.
module temp_disp_ctrl #(
  parameter int REFRESH_DIV = 4
) (
  input  logic       SYSCLK,
  input  logic       RSTN,
  input  logic       sample_valid,
  input  logic [7:0] sample,
  output logic       busy,
  output logic       done,
  output logic       ovr,
  output logic [2:0] an,
  output logic [6:0] seg
);

  localparam logic [1:0]  IDLE = 2'd0;
  localparam logic [1:0]  CONV = 2'd1;
  localparam logic [1:0]  DONE = 2'd2;
  localparam logic [15:0] RMAX = 16'(REFRESH_DIV - 1);

  logic [1:0]  state;
  logic [6:0]  mag_r;
  logic        sign_r;
  logic [11:0] bcd_r;
  logic [2:0]  it;
  logic [10:0] bcd_adj;
  logic        clamp;

  logic [3:0]  disp_h, disp_t, disp_o;
  logic        disp_neg;

  logic [15:0] rcnt;
  logic [1:0]  didx, nxt_idx;
  logic [2:0]  nxt_an;
  logic [6:0]  nxt_seg;

  function automatic logic [3:0] add3(input logic [3:0] n);
    return (n >= 4'd5) ? n + 4'd3 : n;
  endfunction

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    return 7'h3F;
      4'd1:    return 7'h06;
      4'd2:    return 7'h5B;
      4'd3:    return 7'h4F;
      4'd4:    return 7'h66;
      4'd5:    return 7'h6D;
      4'd6:    return 7'h7D;
      4'd7:    return 7'h07;
      4'd8:    return 7'h7F;
      4'd9:    return 7'h6F;
      default: return 7'h00;
    endcase
  endfunction

  // Before the final shift the value is at most 63, so the hundreds nibble never needs adjusting.
  assign bcd_adj = {bcd_r[10:8], add3(bcd_r[7:4]), add3(bcd_r[3:0])};
  assign clamp   = sign_r && (bcd_r[11:8] != 4'd0);

  always_ff @(posedge SYSCLK or negedge RSTN) begin
    if (!RSTN) begin
      state    <= IDLE;
      mag_r    <= '0;
      sign_r   <= 1'b0;
      bcd_r    <= '0;
      it       <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      ovr      <= 1'b0;
      disp_h   <= '0;
      disp_t   <= '0;
      disp_o   <= '0;
      disp_neg <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (sample_valid) begin
            mag_r  <= sample[6:0];
            sign_r <= sample[7];
            bcd_r  <= '0;
            it     <= '0;
            busy   <= 1'b1;
            state  <= CONV;
          end
        end
        CONV: begin
          {bcd_r, mag_r} <= {bcd_adj, mag_r, 1'b0};
          it <= it + 3'd1;
          if (it == 3'd6) state <= DONE;
        end
        DONE: begin
          if (clamp) begin
            disp_h   <= 4'd0;
            disp_t   <= 4'd9;
            disp_o   <= 4'd9;
            disp_neg <= 1'b1;
            ovr      <= 1'b1;
          end else begin
            disp_h   <= bcd_r[11:8];
            disp_t   <= bcd_r[7:4];
            disp_o   <= bcd_r[3:0];
            disp_neg <= sign_r && (bcd_r != 12'd0);
            ovr      <= 1'b0;
          end
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Pattern for the digit about to be selected, loaded together with its anode.
  always_comb begin
    nxt_idx = (didx == 2'd2) ? 2'd0 : didx + 2'd1;
    nxt_an  = 3'b001;
    nxt_seg = 7'h00;
    case (nxt_idx)
      2'd0: begin
        nxt_an  = 3'b001;
        nxt_seg = seg7(disp_o);
      end
      2'd1: begin
        nxt_an  = 3'b010;
        nxt_seg = (disp_h == 4'd0 && disp_t == 4'd0) ? 7'h00 : seg7(disp_t);
      end
      default: begin
        nxt_an  = 3'b100;
        nxt_seg = disp_neg ? 7'h40 : ((disp_h == 4'd1) ? 7'h06 : 7'h00);
      end
    endcase
  end

  always_ff @(posedge SYSCLK or negedge RSTN) begin
    if (!RSTN) begin
      rcnt <= '0;
      didx <= 2'd0;
      an   <= 3'b001;
      seg  <= 7'h3F;
    end else if (rcnt == RMAX) begin
      rcnt <= '0;
      didx <= nxt_idx;
      an   <= nxt_an;
      seg  <= nxt_seg;
    end else begin
      rcnt <= rcnt + 16'd1;
    end
  end

endmodule

// File: doc/temp_disp_ctrl.md
# temp_disp_ctrl

Display controller downstream of the LM07 SPI temperature reader. It accepts one signed temperature byte per strobe and converts the 7-bit magnitude to BCD with a sequential double-dabble engine. It then drives a three-digit, time-multiplexed seven-segment display: sign or hundreds digit, tens, ones. It replaces the free-running BCD/display glue with a strobed, deterministic-latency path.

## Interface
- REFRESH_DIV, 4: SYSCLK cycles each digit stays selected; legal range 1..65535.
- SYSCLK  in  1  system clock; all state changes on the rising edge.
- RSTN  in  1  asynchronous, active-low reset.
- sample_valid  in  1  one-cycle strobe qualifying `sample`.
- sample  in  8  bit7 = sign (1 = negative); bits[6:0] = magnitude 0..127 °C.
- busy  out  1  high while a conversion is in progress.
- done  out  1  one-cycle pulse when the display registers take a new value.
- ovr  out  1  high while the displayed value is clamped.
- an  out  3  one-hot digit select: an[0] = ones, an[1] = tens, an[2] = sign/hundreds.
- seg  out  7  active-high segments {g,f,e,d,c,b,a}.

## Operation
- FSM states: IDLE, CONV, DONE.
- **IDLE**
  - On `sample_valid`: capture `sample[6:0]` into the shift register and `sample[7]` into `sign_r`.
  - Clear the 12-bit BCD accumulator, set `it` = 0, go to CONV.
- **CONV**
  - Each cycle: add 3 to every BCD nibble ≥ 5, then shift {BCD, magnitude} left by 1, then `it` += 1.
  - After the 7th shift (`it` = 6 → 7), go to DONE.
- **DONE**
  - Commit hundreds/tens/ones and sign to the display registers.
  - Pulse `done`, update `ovr`, return to IDLE.
- `sample_valid` in CONV or DONE is ignored; the sample is dropped.
- Clamp: if sign = 1 and magnitude > 99, display −99 and set `ovr` = 1. Otherwise `ovr` = 0.
- Negative zero (8'h80) displays as 0 with no minus; `ovr` = 0.
- Digit content:
  - Ones digit: always shown.
  - Tens digit: blank when hundreds = 0 and tens = 0 (leading-zero suppression).
  - Digit 2: '-' if negative and nonzero; '1' if hundreds = 1; else blank.
- Segment codes:
  - Digits 0–9: 3F, 06, 5B, 4F, 66, 6D, 7D, 07, 7F, 6F.
  - Minus: 40. Blank: 00.
- Refresh:
  - `rcnt` counts 0..REFRESH_DIV−1 continuously, independent of the FSM.
  - On wrap, the digit index advances 0→1→2→0.
  - `an` and `seg` are registered and change on the same edge.

## Timing
- Reset values:
  - State IDLE; `busy` = 0, `done` = 0, `ovr` = 0.
  - Display registers = +0; `rcnt` = 0; digit index = 0.
  - `an` = 3'b001, `seg` = 7'h3F.
- Latency, with strobe sampled at edge E0:
  - `busy` rises after E0.
  - Shifts occur at E1..E7.
  - Commit at E8: `busy` falls, `done` high for the cycle after E8, new `seg` visible from the next digit-select update onward.
- Throughput: one sample per 9 cycles. A strobe at E8 is ignored; a strobe at E9 is accepted.
- Display registers change only at commit. The display never shows a partial conversion.
- With REFRESH_DIV = N, each `an` value persists exactly N cycles, giving a full scan period of 3N.
- RSTN asserted mid-conversion: immediate return to reset values; no `done`; the in-flight sample is lost.
- RSTN deassertion is synchronised by the system-level reset logic; this block does no extra synchronisation.

## Test plan
- Reset, then no strobe → `an` 001/010/100 for 4 cycles each; `seg` = 3F, 00, 00; `busy` = 0.
- `sample` = 8'h19 (+25) → `busy` for 8 cycles, `done` once at E8; digits ones = 6D, tens = 5B, digit 2 = 00; `ovr` = 0.
- `sample` = 8'h8C (−12) → ones = 5B, tens = 06, digit 2 = 40.
- `sample` = 8'h7F (+127) → 07, 5B, 06.
- `sample` = 8'hE4 (−100) → 6F, 6F, 40 with `ovr` = 1.
- `sample` = 8'h80 → 3F, 00, 00; `ovr` = 0.
- Strobe 8'h05, then strobe 8'h09 three cycles later → second strobe ignored; display shows 5.
- Strobe 8'h05, RSTN pulsed low at E4 → no `done`; outputs return to reset values.
- Strobe 8'h09 at E9 → accepted; display shows 9 after the next commit.
